rx_frame_ctrl: RTL and testbench

- Receive-side sequencer sitting directly after the CDR.
- Controls the CDR run/reset and consumes its recovered bit stream (data plus valid strobe).
- Detects preamble, then SFD, then the PHY length byte, and delivers payload bytes over a valid/ready interface to the MAC-side buffer.
- Aborts and re-acquires on errors: zero length, output overflow, or loss of bit strobes.

---
 rtl/rx_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive-side sequencer after the CDR: preamble/SFD/PHR detection, payload byte
// delivery over valid/ready, and abort/re-acquire on zero length, overflow or strobe loss.
//
// state   | meaning
// IDLE    | receiver disabled, CDR held in reset
// RESTART | CDR held in reset for RST_CYC cycles
// PRE     | counting consecutive zero bits
// SFD     | sliding-window search for the delimiter
// LEN     | collecting the PHY length byte
// PAY     | collecting payload bytes
module rx_frame_ctrl #(
  parameter int         PRE_BITS = 16,
  parameter logic [7:0] SFD      = 8'hA7,
  parameter int         SFD_WIN  = 32,
  parameter int         WDOG     = 1024,
  parameter int         RST_CYC  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_bit,
  input  logic       i_bit_vld,
  output logic       o_cdr_run,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_byte_last,
  input  logic       i_byte_rdy,
  output logic [6:0] o_len,
  output logic       o_sync,
  output logic       o_busy,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_PRE     = 3'd2,
    ST_SFD     = 3'd3,
    ST_LEN     = 3'd4,
    ST_PAY     = 3'd5
  } state_t;

  localparam int ZW = $clog2(PRE_BITS + 1);
  localparam int WW = $clog2(SFD_WIN + 1);
  localparam int DW = $clog2(WDOG);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [ZW-1:0] ZERO_TC = ZW'(PRE_BITS - 1);
  localparam logic [WW-1:0] WIN_TC  = WW'(SFD_WIN - 1);
  localparam logic [DW-1:0] WD_LOAD = DW'(WDOG - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic [ZW-1:0] zero_cnt;
  logic [WW-1:0] win_cnt;
  logic [DW-1:0] wd_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic [6:0]    rem;

  logic [7:0] sh_nxt;
  logic       in_frame, byte_done, xfer, ovf, wd_exp, zlen;
  logic       sfd_hit, sfd_miss, pay_last, pre_done, state_chg;
  logic       err_nxt;
  logic [1:0] code_nxt;

  assign sh_nxt    = {i_bit, sh[7:1]};
  assign in_frame  = (state == ST_SFD) || (state == ST_LEN) || (state == ST_PAY);
  assign byte_done = i_bit_vld && (bit_cnt == 3'd7);
  assign xfer      = o_byte_vld && i_byte_rdy;
  assign ovf       = (state == ST_PAY) && byte_done && o_byte_vld && !i_byte_rdy;
  assign wd_exp    = in_frame && !i_bit_vld && (wd_cnt == '0);
  assign zlen      = (state == ST_LEN) && byte_done && (sh_nxt[6:0] == 7'd0);
  assign sfd_hit   = (state == ST_SFD) && i_bit_vld && (sh_nxt == SFD);
  assign sfd_miss  = (state == ST_SFD) && i_bit_vld && !sfd_hit && (win_cnt == WIN_TC);
  assign pay_last  = (state == ST_PAY) && byte_done && (rem == 7'd1);
  assign pre_done  = (state == ST_PRE) && i_bit_vld && !i_bit && (zero_cnt == ZERO_TC);
  assign state_chg = (state_nxt != state);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_RESTART;
        ST_RESTART: if (rst_cnt == '0) state_nxt = ST_PRE;
        ST_PRE:     if (pre_done) state_nxt = ST_SFD;
        ST_SFD: begin
          if (wd_exp)        state_nxt = ST_RESTART;
          else if (sfd_hit)  state_nxt = ST_LEN;
          else if (sfd_miss) state_nxt = ST_PRE;
        end
        ST_LEN: begin
          if (wd_exp || zlen) state_nxt = ST_RESTART;
          else if (byte_done) state_nxt = ST_PAY;
        end
        ST_PAY:     if (ovf || wd_exp || pay_last) state_nxt = ST_RESTART;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_state   = state;
    o_cdr_run = (state == ST_PRE) || in_frame;
    o_busy    = in_frame;
  end

  // Error priority: overflow, then watchdog, then zero length; disable suppresses all.
  always_comb begin
    err_nxt  = 1'b0;
    code_nxt = 2'd0;
    if (i_en) begin
      if (ovf) begin
        err_nxt  = 1'b1;
        code_nxt = 2'd2;
      end else if (wd_exp) begin
        err_nxt  = 1'b1;
        code_nxt = 2'd3;
      end else if (zlen) begin
        err_nxt  = 1'b1;
        code_nxt = 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_cnt     <= '0;
      zero_cnt    <= '0;
      win_cnt     <= '0;
      wd_cnt      <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      rem         <= '0;
      o_len       <= '0;
      o_sync      <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= 2'd0;
      o_byte      <= '0;
      o_byte_vld  <= 1'b0;
      o_byte_last <= 1'b0;
    end else begin
      rst_cnt <= (state == ST_RESTART) ? rst_cnt - 1'b1 : RST_LOAD;

      if (state != ST_PRE || state_chg) zero_cnt <= '0;
      else if (i_bit_vld)               zero_cnt <= i_bit ? '0 : zero_cnt + 1'b1;

      if (state != ST_SFD || state_chg) win_cnt <= '0;
      else if (i_bit_vld)               win_cnt <= win_cnt + 1'b1;

      if (state_chg)                     bit_cnt <= '0;
      else if (i_bit_vld && (state == ST_LEN || state == ST_PAY))
                                         bit_cnt <= bit_cnt + 3'd1;

      if (state_chg)                     sh <= '0;
      else if (i_bit_vld && in_frame)    sh <= sh_nxt;

      if (state_chg || i_bit_vld || !in_frame) wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)                   wd_cnt <= wd_cnt - 1'b1;

      if (state == ST_LEN && byte_done) begin
        rem   <= sh_nxt[6:0];
        o_len <= sh_nxt[6:0];
      end else if (state == ST_PAY && byte_done) begin
        rem <= rem - 7'd1;
      end

      o_sync <= sfd_hit && i_en;
      o_err  <= err_nxt;
      if (err_nxt) o_err_code <= code_nxt;

      if (!i_en || ovf || wd_exp) begin
        o_byte_vld  <= 1'b0;
        o_byte_last <= 1'b0;
      end else if (state == ST_PAY && byte_done) begin
        o_byte      <= sh_nxt;
        o_byte_vld  <= 1'b1;
        o_byte_last <= (rem == 7'd1);
      end else if (xfer) begin
        o_byte_vld  <= 1'b0;
        o_byte_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: bits are strobed every 4 cycles, LSB first,
// and outputs are captured 1 time unit after the edge that samples each strobe.
module tb_rx_frame_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_bit, i_bit_vld, i_byte_rdy;
  logic       o_cdr_run, o_byte_vld, o_byte_last, o_sync, o_busy, o_err;
  logic [7:0] o_byte;
  logic [6:0] o_len;
  logic [1:0] o_err_code;
  logic [2:0] o_state;

  int n_chk = 0, n_pass = 0;
  int sync_cnt = 0, err_cnt = 0, xfer_cnt = 0, b33_cnt = 0;
  int base_sync, base_err, base_xfer, base_b33, low_cnt;
  logic       s_vld, s_last, s_sync, s_err;
  logic [7:0] s_byte;
  logic [1:0] s_code;
  logic [2:0] s_state;

  rx_frame_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_bit(i_bit), .i_bit_vld(i_bit_vld),
    .o_cdr_run(o_cdr_run), .o_byte(o_byte), .o_byte_vld(o_byte_vld),
    .o_byte_last(o_byte_last), .i_byte_rdy(i_byte_rdy), .o_len(o_len), .o_sync(o_sync),
    .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_sync) sync_cnt++;
      if (o_err) err_cnt++;
      if (o_byte_vld && i_byte_rdy) xfer_cnt++;
      if (o_byte_vld && o_byte == 8'h33) b33_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_bit = b;
    i_bit_vld = 1'b1;
    tick();
    i_bit_vld = 1'b0;
    i_bit = 1'b0;
    s_vld = o_byte_vld; s_byte = o_byte; s_last = o_byte_last; s_sync = o_sync;
    s_err = o_err; s_code = o_err_code; s_state = o_state;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_pre;
    repeat (16) send_bit(1'b0);
  endtask

  task automatic wait_pre(input string tag);
    int n = 0;
    while (o_state !== 3'd2 && n < 100) begin
      tick();
      n++;
    end
    check(tag, o_state, 3'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_bit = 1'b0; i_bit_vld = 1'b0; i_byte_rdy = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_state", o_state, 3'd0);
    check("rst_cdr", o_cdr_run, 1'b0);
    check("rst_vld", o_byte_vld, 1'b0);
    check("rst_err", {o_err, o_err_code}, 3'd0);
    check("rst_len", o_len, 7'd0);

    // enable: RESTART keeps the CDR in reset for exactly 4 cycles
    i_en = 1'b1;
    tick();
    check("en_state", o_state, 3'd1);
    low_cnt = 0;
    while (o_cdr_run == 1'b0 && low_cnt < 20) begin
      low_cnt++;
      tick();
    end
    check("restart_len", low_cnt, 4);
    check("restart_pre", o_state, 3'd2);
    check("restart_cdr", o_cdr_run, 1'b1);

    // nominal frame, downstream always ready
    base_sync = sync_cnt; base_err = err_cnt; base_xfer = xfer_cnt;
    send_pre();
    send_byte(8'hA7);
    check("f1_sync", s_sync, 1'b1);
    check("f1_len_state", s_state, 3'd4);
    send_byte(8'h03);
    check("f1_len", o_len, 7'd3);
    check("f1_pay_state", s_state, 3'd5);
    send_byte(8'h11);
    check("f1_b0", {s_vld, s_last, s_byte}, {2'b10, 8'h11});
    send_byte(8'h22);
    check("f1_b1", {s_vld, s_last, s_byte}, {2'b10, 8'h22});
    send_byte(8'h33);
    check("f1_b2", {s_vld, s_last, s_byte}, {2'b11, 8'h33});
    check("f1_end_state", s_state, 3'd1);
    check("f1_sync_cnt", sync_cnt - base_sync, 1);
    check("f1_xfer_cnt", xfer_cnt - base_xfer, 3);
    check("f1_err_cnt", err_cnt - base_err, 0);

    // overflow: downstream stalls from 0x22 onwards
    wait_pre("f2_pre");
    send_pre();
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    check("f2_b0", s_byte, 8'h11);
    i_byte_rdy = 1'b0;
    send_byte(8'h22);
    check("f2_b1", {s_vld, s_byte}, {1'b1, 8'h22});
    base_b33 = b33_cnt;
    send_byte(8'h33);
    check("f2_ovf_err", {s_err, s_code}, {1'b1, 2'd2});
    check("f2_ovf_vld", s_vld, 1'b0);
    check("f2_ovf_state", s_state, 3'd1);
    check("f2_no_33", b33_cnt - base_b33, 0);
    check("f2_code_held", o_err_code, 2'd2);
    i_byte_rdy = 1'b1;

    // SFD window expiry, then a normal frame
    wait_pre("f3_pre");
    base_sync = sync_cnt;
    send_pre();
    for (int i = 0; i < 32; i++) begin
      send_bit((i % 2) == 0);
      if (i == 30) check("f3_win_31", s_state, 3'd3);
      if (i == 31) check("f3_win_32", s_state, 3'd2);
    end
    check("f3_no_sync", sync_cnt - base_sync, 0);
    send_pre();
    send_byte(8'hA7);
    send_byte(8'h01);
    send_byte(8'h5A);
    check("f3_byte", {s_vld, s_last, s_byte}, {2'b11, 8'h5A});
    check("f3_sync_cnt", sync_cnt - base_sync, 1);

    // zero length (bit 7 set but ignored)
    wait_pre("f4_pre");
    base_xfer = xfer_cnt;
    send_pre();
    send_byte(8'hA7);
    send_byte(8'h80);
    check("f4_err", {s_err, s_code}, {1'b1, 2'd1});
    check("f4_state", s_state, 3'd1);
    check("f4_len", o_len, 7'd0);
    check("f4_no_byte", xfer_cnt - base_xfer, 0);

    // watchdog: 3 idle cycles already elapsed inside send_bit after the last strobe
    wait_pre("f5_pre");
    send_pre();
    send_byte(8'hA7);
    check("f5_len_state", s_state, 3'd4);
    repeat (1020) tick();
    check("f5_wd_early", {o_err, o_state}, {1'b0, 3'd4});
    tick();
    check("f5_wd_err", {o_err, o_err_code}, {1'b1, 2'd3});
    check("f5_wd_state", o_state, 3'd1);

    // disable mid-payload with a byte held
    wait_pre("f6_pre");
    i_byte_rdy = 1'b0;
    send_pre();
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h44);
    check("f6_held", {s_vld, s_byte, s_state}, {1'b1, 8'h44, 3'd5});
    check("f6_still_held", o_byte_vld, 1'b1);
    base_err = err_cnt;
    i_en = 1'b0;
    tick();
    check("f6_idle", o_state, 3'd0);
    check("f6_vld", o_byte_vld, 1'b0);
    check("f6_cdr", o_cdr_run, 1'b0);
    check("f6_no_err", o_err, 1'b0);
    tick();
    check("f6_err_cnt", err_cnt - base_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
